ifm_stream_gen: RTL and testbench
=================================

Name: ifm_stream_gen

Overview:
- Transmit end of the 32-bit IFM window-shift protocol. Reads a single-channel IFM from a pixel SRAM and drives the IFM window buffer.
- Emits command words {cmd[31:24], p0[23:16], p1[15:8], p2[7:0]} in a snake traversal, so the buffer holds every 3x3 window exactly once.
- Sits between the IFM SRAM and the window buffer / PE array front end.

Parameters:
IFM_H, 8, IFM rows (>=3)
IFM_W, 8, IFM columns (>=3)
PIXEL_WIDTH, 8, pixel width (fixed 8 by word format)
ADDR_WIDTH, 16, SRAM address width
POS_WIDTH, 8, width of win_row/win_col

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin a frame; ignored while busy
hold  in  1  downstream stall; suppresses emission
rd_en  out  1  SRAM read strobe
rd_addr  out  ADDR_WIDTH  row*IFM_W+col, row-major, base 0
rd_data  in  PIXEL_WIDTH  SRAM data, valid 1 cycle after rd_en
ifm_word  out  32  command word to window buffer ifm_input
valid_read  out  1  word strobe to window buffer valid_read
win_valid  out  1  pulse: buffer holds a complete window (cycle after the completing word)
win_row  out  POS_WIDTH  top row of window flagged by win_valid
win_col  out  POS_WIDTH  left col of window flagged by win_valid
busy  out  1  frame in progress
done  out  1  1-cycle pulse after final word accepted

Behaviour:
- Reset: all outputs 0; FSM IDLE; first_frame=1. Reset mid-frame aborts immediately; next start restarts from window (0,0).
- Commands: ALL=8'h00, RIGHT=8'h01, LEFT=8'h02, DOWN=8'hFF.
- Packing for ALL/RIGHT/LEFT: column vector at col c', rows r..r+2 (top row in [23:16]).
- Packing for DOWN: row r+3, cols c..c+2 (leftmost col in [23:16]).
- Traversal, window (r,c), starting at (0,0) moving right:
  - Load cols 0,1,2. If first_frame: cmd ALL. Otherwise: cmd RIGHT, because the buffer's ALL counter only clears on reset.
  - Moving right while c<IFM_W-3: RIGHT, col c+3, c++.
  - Moving left while c>0: LEFT, col c-1, rows r..r+2, c--.
  - At a row end, if r<IFM_H-3: DOWN, r++, flip direction. Otherwise: frame ends.
  - IFM_W=3: DOWNs only.
- Totals: 3+(IFM_H-2)*(IFM_W-2)-1 words; (IFM_H-2)*(IFM_W-2) windows.
- FSM states and per-word timing:
  - IDLE: leave on start.
  - RD: 3 cycles, k=0..2, rd_en=1, one pixel address per cycle.
  - LAT: 1 cycle, captures the third pixel. ifm_word is registered here and held stable until the next LAT.
  - EMIT: valid_read = !hold. While hold=1, stay in EMIT with the word stable. On the accepted cycle, advance position; go to RD, or to DONE if last.
  - DONE: 1 cycle, done=1, first_frame<=0, then IDLE.
  - Minimum 5 cycles/word.
- Pixel capture: read k is captured in the cycle after its rd_en.
- win_valid fires on the cycle after an accepted word when the window is complete: the 3rd load word, then every subsequent word. win_row/win_col are valid with it and hold otherwise.
- busy=1 from the cycle after start through DONE.
- Start coincident with DONE or while busy: ignored.
- hold outside EMIT: no effect.

Decomposition:
- Package ifm_pkg:
  - CMD_ALL/CMD_RIGHT/CMD_LEFT/CMD_DOWN constants.
  - FSM state enum {IDLE,RD,LAT,EMIT,DONE}.
  - Direction enum {DIR_R,DIR_L}.
- Optional sub-module ifm_pos_ctrl: window position/direction counters plus next-command and address-generation logic. FSM and word packing stay in the top.

Test Plan (SRAM pixel = row*16+col):
- H=4,W=5, first frame, hold=0 -> words 00001020,00011121,00021222,01031323,01041424,FF323334,02112131,02102030. 6 win_valid at (0,0),(0,1),(0,2),(1,2),(1,1),(1,0). done at cycle ~41.
- Second start, same config -> words 01001020,01011121,01021222 (no ALL), then identical remainder. First win_valid only after the third word.
- hold=1 for 4 cycles during the 4th EMIT -> valid_read stays low; ifm_word=01031323 stays stable; accepted once, no duplicate; total time +4.
- H=4,W=3 -> 00001020,00011121,00021222,FF303132. win_valid (0,0),(1,0). done.
- rst_n low mid-frame during RD -> all outputs 0 asynchronously. Next start emits ALL words from (0,0).
- start pulsed while busy and coincident with DONE -> ignored; word count unchanged.

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared command codes, FSM/direction encodings and frame-size helper for the IFM stream generator.
package ifm_pkg;

   localparam logic [7:0] CMD_ALL   = 8'h00;
   localparam logic [7:0] CMD_RIGHT = 8'h01;
   localparam logic [7:0] CMD_LEFT  = 8'h02;
   localparam logic [7:0] CMD_DOWN  = 8'hFF;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      LAT,
      EMIT,
      DONE
   } state_e;

   typedef enum logic {
      DIR_R,
      DIR_L
   } dir_e;

   // Three load words, then one word per additional window.
   function automatic int frame_words(input int h, input int w);
      return 3 + (h - 2) * (w - 2) - 1;
   endfunction

endpackage

// File: rtl/ifm_stream_gen_if.sv
// SRAM read port plus window-buffer command stream; master = generator, slave = SRAM/buffer side.
interface ifm_stream_gen_if #(
   parameter int PIXEL_WIDTH = 8,
   parameter int ADDR_WIDTH  = 16,
   parameter int POS_WIDTH   = 8
);
   import ifm_pkg::*;

   logic                    rd_en;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [PIXEL_WIDTH-1:0]  rd_data;
   logic                    hold;
   logic [WORD_W-1:0]       ifm_word;
   logic                    valid_read;
   logic                    win_valid;
   logic [POS_WIDTH-1:0]    win_row;
   logic [POS_WIDTH-1:0]    win_col;

   modport master (
      output rd_en, rd_addr, ifm_word, valid_read, win_valid, win_row, win_col,
      input  rd_data, hold
   );

   modport slave (
      input  rd_en, rd_addr, ifm_word, valid_read, win_valid, win_row, win_col,
      output rd_data, hold
   );

endinterface

// File: rtl/ifm_pos_ctrl.sv
// Snake-traversal window position, next command and per-read SRAM address; advances only on an accepted word.
module ifm_pos_ctrl
   import ifm_pkg::*;
#(
   parameter int IFM_H      = 8,
   parameter int IFM_W      = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int POS_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init,
   input  logic                  advance,
   input  logic                  first_frame,
   input  logic [1:0]            rd_idx,
   output logic [7:0]            cmd,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last,
   output logic                  win_complete,
   output logic [POS_WIDTH-1:0]  nxt_row,
   output logic [POS_WIDTH-1:0]  nxt_col
);

   localparam int TOTAL = frame_words(IFM_H, IFM_W);
   localparam int CNT_W = $clog2(TOTAL + 1);

   localparam logic [CNT_W-1:0]      LAST_WORD  = CNT_W'(TOTAL - 1);
   localparam logic [POS_WIDTH-1:0]  LAST_COL   = POS_WIDTH'(IFM_W - 3);
   localparam logic [POS_WIDTH-1:0]  ONE        = POS_WIDTH'(1);
   localparam logic [POS_WIDTH-1:0]  THREE      = POS_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(IFM_W);

   logic [POS_WIDTH-1:0] row_q, col_q;
   dir_e                 dir_q, nxt_dir;
   logic                 loading_q;
   logic [1:0]           lcnt_q;
   logic [CNT_W-1:0]     wcnt_q;

   logic                 is_down;
   logic [POS_WIDTH-1:0] src_col, row_sel, col_sel;

   always_comb begin
      cmd     = CMD_RIGHT;
      is_down = 1'b0;
      src_col = col_q;
      nxt_row = row_q;
      nxt_col = col_q;
      nxt_dir = dir_q;
      if (loading_q) begin
         // The buffer's ALL counter only clears on reset, so reloads after frame one use RIGHT.
         cmd     = first_frame ? CMD_ALL : CMD_RIGHT;
         src_col = POS_WIDTH'(lcnt_q);
      end else if (dir_q == DIR_R && col_q < LAST_COL) begin
         cmd     = CMD_RIGHT;
         src_col = col_q + THREE;
         nxt_col = col_q + ONE;
      end else if (dir_q == DIR_L && col_q != '0) begin
         cmd     = CMD_LEFT;
         src_col = col_q - ONE;
         nxt_col = col_q - ONE;
      end else begin
         cmd     = CMD_DOWN;
         is_down = 1'b1;
         nxt_row = row_q + ONE;
         if (dir_q == DIR_R) begin
            nxt_dir = DIR_L;
         end else begin
            nxt_dir = DIR_R;
         end
      end

      if (is_down) begin
         row_sel = row_q + THREE;
         col_sel = col_q + POS_WIDTH'(rd_idx);
      end else begin
         row_sel = row_q + POS_WIDTH'(rd_idx);
         col_sel = src_col;
      end
   end

   assign addr         = ADDR_WIDTH'(row_sel) * ROW_STRIDE + ADDR_WIDTH'(col_sel);
   assign last         = (wcnt_q == LAST_WORD);
   assign win_complete = !loading_q || (lcnt_q == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q     <= '0;
         col_q     <= '0;
         dir_q     <= DIR_R;
         loading_q <= 1'b0;
         lcnt_q    <= '0;
         wcnt_q    <= '0;
      end else if (init) begin
         row_q     <= '0;
         col_q     <= '0;
         dir_q     <= DIR_R;
         loading_q <= 1'b1;
         lcnt_q    <= '0;
         wcnt_q    <= '0;
      end else if (advance) begin
         wcnt_q <= wcnt_q + CNT_W'(1);
         if (loading_q) begin
            lcnt_q <= lcnt_q + 2'd1;
            if (lcnt_q == 2'd2) begin
               loading_q <= 1'b0;
            end
         end else begin
            row_q <= nxt_row;
            col_q <= nxt_col;
            dir_q <= nxt_dir;
         end
      end
   end

endmodule

// File: rtl/ifm_stream_gen.sv
// Reads 3 pixels per word from SRAM and emits snake-order window-shift commands; 5 cycles/word minimum.
// hold stalls only in EMIT, keeping ifm_word stable until accepted.
module ifm_stream_gen
   import ifm_pkg::*;
#(
   parameter int IFM_H       = 8,
   parameter int IFM_W       = 8,
   parameter int PIXEL_WIDTH = 8,
   parameter int ADDR_WIDTH  = 16,
   parameter int POS_WIDTH   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   ifm_stream_gen_if.master bus
);

   state_e                   state_q, state_d;
   logic [1:0]               k_q;
   logic [PIXEL_WIDTH-1:0]   p0_q, p1_q;
   logic [WORD_W-1:0]        word_q;
   logic                     win_vld_q;
   logic [POS_WIDTH-1:0]     win_row_q, win_col_q;
   logic                     first_frame_q;

   logic                     init, accept, rd_en;
   logic                     last, win_complete;
   logic [7:0]               cmd;
   logic [ADDR_WIDTH-1:0]    addr;
   logic [POS_WIDTH-1:0]     nxt_row, nxt_col;

   ifm_pos_ctrl #(
      .IFM_H      (IFM_H),
      .IFM_W      (IFM_W),
      .ADDR_WIDTH (ADDR_WIDTH),
      .POS_WIDTH  (POS_WIDTH)
   ) u_pos (
      .clk          (clk),
      .rst_n        (rst_n),
      .init         (init),
      .advance      (accept),
      .first_frame  (first_frame_q),
      .rd_idx       (k_q),
      .cmd          (cmd),
      .addr         (addr),
      .last         (last),
      .win_complete (win_complete),
      .nxt_row      (nxt_row),
      .nxt_col      (nxt_col)
   );

   always_comb begin
      state_d = state_q;
      init    = 1'b0;
      accept  = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               init    = 1'b1;
               state_d = RD;
            end
         end
         RD: begin
            rd_en = 1'b1;
            if (k_q == 2'd2) begin
               state_d = LAT;
            end
         end
         LAT: state_d = EMIT;
         EMIT: begin
            if (!bus.hold) begin
               accept  = 1'b1;
               state_d = last ? DONE : RD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q           <= '0;
         p0_q          <= '0;
         p1_q          <= '0;
         word_q        <= '0;
         win_vld_q     <= 1'b0;
         win_row_q     <= '0;
         win_col_q     <= '0;
         first_frame_q <= 1'b1;
      end else begin
         k_q <= (state_q == RD && k_q != 2'd2) ? k_q + 2'd1 : 2'd0;
         // SRAM data for read k lands one cycle after its strobe.
         if (state_q == RD && k_q == 2'd1) begin
            p0_q <= bus.rd_data;
         end
         if (state_q == RD && k_q == 2'd2) begin
            p1_q <= bus.rd_data;
         end
         if (state_q == LAT) begin
            word_q <= {cmd, p0_q, p1_q, bus.rd_data};
         end
         win_vld_q <= accept && win_complete;
         if (accept && win_complete) begin
            win_row_q <= nxt_row;
            win_col_q <= nxt_col;
         end
         if (state_q == DONE) begin
            first_frame_q <= 1'b0;
         end
      end
   end

   assign bus.rd_en      = rd_en;
   assign bus.rd_addr    = rd_en ? addr : '0;
   assign bus.ifm_word   = word_q;
   assign bus.valid_read = accept;
   assign bus.win_valid  = win_vld_q;
   assign bus.win_row    = win_row_q;
   assign bus.win_col    = win_col_q;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);

endmodule

// File: tb/tb_ifm_stream_gen.sv
// Directed bench: two generator instances (4x5 and 4x3) against an SRAM model holding pixel = row*16+col.
module tb_ifm_stream_gen;
   import ifm_pkg::*;

   localparam int HA = 4;
   localparam int WA = 5;
   localparam int HB = 4;
   localparam int WB = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start_a, start_b;
   logic busy_a, done_a, busy_b, done_b;

   ifm_stream_gen_if #(.PIXEL_WIDTH(8), .ADDR_WIDTH(16), .POS_WIDTH(8)) ifa ();
   ifm_stream_gen_if #(.PIXEL_WIDTH(8), .ADDR_WIDTH(16), .POS_WIDTH(8)) ifb ();

   ifm_stream_gen #(.IFM_H(HA), .IFM_W(WA), .PIXEL_WIDTH(8), .ADDR_WIDTH(16), .POS_WIDTH(8)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_a),
      .busy  (busy_a),
      .done  (done_a),
      .bus   (ifa)
   );

   ifm_stream_gen #(.IFM_H(HB), .IFM_W(WB), .PIXEL_WIDTH(8), .ADDR_WIDTH(16), .POS_WIDTH(8)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_b),
      .busy  (busy_b),
      .done  (done_b),
      .bus   (ifb)
   );

   function automatic logic [7:0] pix(input logic [15:0] a, input int w);
      int r, c;
      r = int'(a) / w;
      c = int'(a) % w;
      return 8'(r * 16 + c);
   endfunction

   always_ff @(posedge clk) begin
      ifa.rd_data <= ifa.rd_en ? pix(ifa.rd_addr, WA) : 8'h00;
      ifb.rd_data <= ifb.rd_en ? pix(ifb.rd_addr, WB) : 8'h00;
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] words[$];
   logic [15:0] wins[$];
   int          win_at[$];
   int          fr_cycles;
   bit          fr_done;
   int          hold_seen;

   logic [31:0] exp_w[$];
   logic [15:0] exp_p[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Runs one frame, recording accepted words and flagged windows as seen at the negedge.
   task automatic run_frame(input bit sel_b, input int hold_at, input int hold_n,
                            input int xs1, input int xs2, input logic [31:0] hold_word);
      logic [31:0] last_acc;
      logic        vr, wv, dn;
      logic [31:0] w;
      logic [15:0] pos;
      words.delete();
      wins.delete();
      win_at.delete();
      fr_cycles = 0;
      fr_done   = 1'b0;
      hold_seen = 0;
      last_acc  = '0;
      @(posedge clk);
      #1;
      if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      for (int i = 0; i < 300 && !fr_done; i++) begin
         @(posedge clk);
         fr_cycles++;
         #1;
         start_a = 1'b0;
         start_b = 1'b0;
         if (fr_cycles == xs1 || fr_cycles == xs2) begin
            if (sel_b) start_b = 1'b1; else start_a = 1'b1;
         end
         ifa.hold = !sel_b && (words.size() == hold_at) && (hold_seen < hold_n);
         @(negedge clk);
         vr  = sel_b ? ifb.valid_read : ifa.valid_read;
         wv  = sel_b ? ifb.win_valid  : ifa.win_valid;
         dn  = sel_b ? done_b         : done_a;
         w   = sel_b ? ifb.ifm_word   : ifa.ifm_word;
         pos = sel_b ? {ifb.win_row, ifb.win_col} : {ifa.win_row, ifa.win_col};
         if (!sel_b && ifa.hold && ifa.ifm_word != last_acc) begin
            hold_seen++;
            check("hold_valid_read", 32'(ifa.valid_read), 32'd0);
            check("hold_word_stable", ifa.ifm_word, hold_word);
         end
         if (vr) begin
            words.push_back(w);
            last_acc = w;
         end
         if (wv) begin
            wins.push_back(pos);
            win_at.push_back(words.size());
         end
         if (dn) fr_done = 1'b1;
      end
      @(posedge clk);
      #1;
      start_a  = 1'b0;
      start_b  = 1'b0;
      ifa.hold = 1'b0;
      check("frame_done_seen", 32'(fr_done), 32'd1);
   endtask

   task automatic check_frame(input string tag, input int cycles);
      check({tag, "_nwords"}, 32'(words.size()), 32'(exp_w.size()));
      foreach (exp_w[i])
         check($sformatf("%s_word%0d", tag, i), (i < words.size()) ? words[i] : 32'hDEADBEEF, exp_w[i]);
      check({tag, "_nwins"}, 32'(wins.size()), 32'(exp_p.size()));
      foreach (exp_p[i])
         check($sformatf("%s_win%0d", tag, i), 32'((i < wins.size()) ? wins[i] : 16'hFFFF), 32'(exp_p[i]));
      check({tag, "_first_win_after"}, 32'((win_at.size() > 0) ? win_at[0] : -1), 32'd3);
      check({tag, "_cycles"}, 32'(fr_cycles), 32'(cycles));
   endtask

   initial begin
      rst_n    = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      ifa.hold = 1'b0;
      ifb.hold = 1'b0;
      #12;
      check("rst_rd_en",      32'(ifa.rd_en), 32'd0);
      check("rst_rd_addr",    32'(ifa.rd_addr), 32'd0);
      check("rst_ifm_word",   ifa.ifm_word, 32'd0);
      check("rst_valid_read", 32'(ifa.valid_read), 32'd0);
      check("rst_win_valid",  32'(ifa.win_valid), 32'd0);
      check("rst_win_pos",    32'({ifa.win_row, ifa.win_col}), 32'd0);
      check("rst_busy",       32'(busy_a), 32'd0);
      check("rst_done",       32'(done_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // First frame: ALL loads.
      exp_w = '{32'h00001020, 32'h00011121, 32'h00021222, 32'h01031323,
                32'h01041424, 32'hFF323334, 32'h02112131, 32'h02102030};
      exp_p = '{16'h0000, 16'h0001, 16'h0002, 16'h0102, 16'h0101, 16'h0100};
      run_frame(1'b0, -1, 0, -1, -1, 32'h0);
      check_frame("f1", 41);
      check("f1_idle_busy", 32'(busy_a), 32'd0);

      // Second frame: RIGHT loads; extra starts while busy and on DONE are ignored.
      exp_w = '{32'h01001020, 32'h01011121, 32'h01021222, 32'h01031323,
                32'h01041424, 32'hFF323334, 32'h02112131, 32'h02102030};
      run_frame(1'b0, -1, 0, 10, 41, 32'h0);
      check_frame("f2", 41);
      repeat (3) @(negedge clk);
      check("f2_no_restart_busy", 32'(busy_a), 32'd0);

      // Third frame: 4-cycle stall on the fourth word.
      run_frame(1'b0, 3, 4, -1, -1, 32'h01031323);
      check_frame("f3", 45);
      check("f3_hold_cycles", 32'(hold_seen), 32'd4);

      // Reset in the middle of RD.
      @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      @(posedge clk);
      #2;
      check("mid_busy_before", 32'(busy_a), 32'd1);
      check("mid_rd_en_before", 32'(ifa.rd_en), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rd_en",    32'(ifa.rd_en), 32'd0);
      check("mid_rst_rd_addr",  32'(ifa.rd_addr), 32'd0);
      check("mid_rst_busy",     32'(busy_a), 32'd0);
      check("mid_rst_ifm_word", ifa.ifm_word, 32'd0);
      check("mid_rst_win_pos",  32'({ifa.win_row, ifa.win_col}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      exp_w = '{32'h00001020, 32'h00011121, 32'h00021222, 32'h01031323,
                32'h01041424, 32'hFF323334, 32'h02112131, 32'h02102030};
      run_frame(1'b0, -1, 0, -1, -1, 32'h0);
      check_frame("f4", 41);

      // Three-column IFM: DOWN only after the load.
      exp_w = '{32'h00001020, 32'h00011121, 32'h00021222, 32'hFF303132};
      exp_p = '{16'h0000, 16'h0100};
      run_frame(1'b1, -1, 0, -1, -1, 32'h0);
      check_frame("fb", 21);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
